pipelined_csa_addsub: RTL and testbench

//  Parametrised, pipelined carry-select adder/subtractor for the SimpleALU datapath.

---
 rtl/pipelined_csa_addsub.sv | 147 ++++++++++++++
 tb/tb_pipelined_csa_addsub.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_csa_addsub.sv
// Pipelined carry-select adder/subtractor: one BLK-bit block resolved per stage, NB stages.
// Optional saturation on signed overflow is enabled by defining CSA_SAT_EN (adds port sat).
module pipelined_csa_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLK   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             op,
`ifdef CSA_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int unsigned NB = (BLK == 0) ? 1 : WIDTH / BLK;

    if (BLK < 1) begin : g_bad_blk
        $error("pipelined_csa_addsub: BLK must be at least 1");
    end else if ((WIDTH % BLK) != 0 || WIDTH < BLK) begin : g_bad_width
        $error("pipelined_csa_addsub: WIDTH must be a non-zero multiple of BLK");
    end

    // Per-stage state: operands (B already inverted for sub), partially resolved sum,
    // carry out of the most recently resolved block, valid and saturation request.
    logic [WIDTH-1:0] a_q [NB];
    logic [WIDTH-1:0] a_d [NB];
    logic [WIDTH-1:0] b_q [NB];
    logic [WIDTH-1:0] b_d [NB];
    logic [WIDTH-1:0] s_q [NB];
    logic [WIDTH-1:0] s_d [NB];
    logic [NB-1:0]    c_q, c_d;
    logic [NB-1:0]    vld_q, vld_d;
    logic [NB-1:0]    sat_q, sat_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] src_a [NB];
    logic [WIDTH-1:0] src_b [NB];
    logic [WIDTH-1:0] src_s [NB];
    logic [NB-1:0]    src_c, src_v, src_sat;

    logic             stall;
    logic             op_m;
    logic             sat_in;
    logic [WIDTH-1:0] a_in, b_in;
    logic             c_msb;

    assign stall    = vld_q[NB-1] & ~out_ready;
    assign in_ready = ~stall;

    // Operands are masked when idle so unknown inputs never enter the pipe.
    assign op_m = in_valid & op;
    assign a_in = in_valid ? in1 : '0;
    assign b_in = in_valid ? (op_m ? ~in2 : in2) : '0;
`ifdef CSA_SAT_EN
    assign sat_in = in_valid & sat;
`else
    assign sat_in = 1'b0;
`endif

    always_comb begin
        src_a[0]   = a_in;
        src_b[0]   = b_in;
        src_s[0]   = '0;
        src_c[0]   = op_m ? 1'b1 : (in_valid & cin);
        src_v[0]   = in_valid;
        src_sat[0] = sat_in;
        for (int k = 1; k < NB; k++) begin
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_s[k]   = s_q[k-1];
            src_c[k]   = c_q[k-1];
            src_v[k]   = vld_q[k-1];
            src_sat[k] = sat_q[k-1];
        end
    end

    always_comb begin
        logic [BLK:0] sum_c0;
        logic [BLK:0] sum_c1;
        logic [BLK:0] sum_sel;
        for (int k = 0; k < NB; k++) begin
            // Both carry hypotheses are formed; the incoming carry only picks one.
            sum_c0  = {1'b0, src_a[k][k*BLK +: BLK]} + {1'b0, src_b[k][k*BLK +: BLK]};
            sum_c1  = sum_c0 + (BLK+1)'(1);
            sum_sel = src_c[k] ? sum_c1 : sum_c0;
            a_d[k]   = src_a[k];
            b_d[k]   = src_b[k];
            s_d[k]   = src_s[k];
            s_d[k][k*BLK +: BLK] = sum_sel[BLK-1:0];
            c_d[k]   = sum_sel[BLK];
            vld_d[k] = src_v[k];
            sat_d[k] = src_sat[k];
        end
        // Carry into the MSB recovered from the MSB sum bit.
        c_msb = a_d[NB-1][WIDTH-1] ^ b_d[NB-1][WIDTH-1] ^ s_d[NB-1][WIDTH-1];
        ovf_d = c_msb ^ c_d[NB-1];
        if (sat_d[NB-1] && ovf_d) begin
            s_d[NB-1] = a_d[NB-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
        end
        zero_d = (s_d[NB-1] == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NB; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q    <= '0;
            vld_q  <= '0;
            sat_q  <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < NB; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
            c_q    <= c_d;
            vld_q  <= vld_d;
            sat_q  <= sat_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = vld_q[NB-1];
    assign sum       = s_q[NB-1];
    assign cout      = c_q[NB-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_csa_addsub.sv
// Directed self-checking bench for pipelined_csa_addsub (WIDTH=32, BLK=8, NB=4).
module tb_pipelined_csa_addsub;
    localparam int unsigned W  = 32;
    localparam int unsigned NB = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         cin = 1'b0;
    logic         op = 1'b0;
    logic         sat = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_rcv = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    logic [W:0] exp_q [$];

    pipelined_csa_addsub #(.WIDTH(W), .BLK(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in1      (in1),
        .in2      (in2),
        .cin      (cin),
        .op       (op),
`ifdef CSA_SAT_EN
        .sat      (sat),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .zero     (zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {cout, sum} of the unsaturated operation.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic o);
        if (o) return {1'b0, a} + {1'b0, ~b} + 33'd1;
        return {1'b0, a} + {1'b0, b} + {32'd0, c};
    endfunction

    // Scoreboard both handshakes for the coming edge, then advance one clock.
    task automatic cycle();
        if (in_valid && in_ready) exp_q.push_back(model(in1, in2, cin, op));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", {63'd0, out_valid}, 64'd0);
            end else begin
                check("stream", {31'd0, cout, sum}, {31'd0, exp_q.pop_front()});
                n_rcv++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic o, input logic s,
                           input logic [W-1:0] e_sum, input logic e_cout,
                           input logic e_ovf, input logic e_zero);
        int lat;
        in1 = a; in2 = b; cin = c; op = o; sat = s; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0; in1 = 'x; in2 = 'x; cin = 1'bx; op = 1'bx; sat = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            cycle();
            lat++;
        end
        check({tag, "_lat"}, lat, NB);
        check({tag, "_sum"}, sum, e_sum);
        check({tag, "_cout"}, cout, e_cout);
        check({tag, "_ovf"}, ovf, e_ovf);
        check({tag, "_zero"}, zero, e_zero);
        if (s) void'(exp_q.pop_back());
        if (s) begin
            @(posedge clock);
            #1;
        end else begin
            cycle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_flags", {cout, ovf, zero}, 0);
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);

        run_one("add_xblk", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0,
                32'h0000_0100, 1'b0, 1'b0, 1'b0);
        run_one("add_ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0,
                32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_one("sub_5_7", 32'd5, 32'd7, 1'b1, 1'b1, 1'b0,
                32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_one("sub_min_1", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b0,
                32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_one("sub_eq", 32'd7, 32'd7, 1'b0, 1'b1, 1'b0,
                32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_one("add_ovf_wrap", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0,
                32'h8000_0000, 1'b0, 1'b1, 1'b0);
`ifdef CSA_SAT_EN
        run_one("sat_pos", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1,
                32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_one("sat_neg", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b1,
                32'h8000_0000, 1'b1, 1'b1, 1'b0);
`endif

        // Back-to-back stream of 8 ops with the sink always ready.
        n_rcv = 0; first_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            in1 = 32'h0F0F_0F0F + i * 32'h0101_0101;
            in2 = 32'h00FF_FF00 ^ (i << 4);
            cin = i[0]; op = i[1]; in_valid = 1'b1;
            check("b2b_in_ready", in_ready, 1);
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        check("b2b_count", n_rcv, 8);
        check("b2b_consecutive", last_cyc - first_cyc, 7);

        // Fill the pipe with the sink stalled, hold, then drain.
        out_ready = 1'b0; n_rcv = 0;
        for (int i = 0; i < 4; i++) begin
            in1 = i * 32'h1000_0001; in2 = 32'd3; cin = 1'b0; op = i[0]; in_valid = 1'b1;
            cycle();
        end
        in1 = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_sum", sum, exp_q[0][W-1:0]);
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        check("bp_drained", n_rcv, 4);
        check("bp_queue_empty", exp_q.size(), 0);

        // Asynchronous reset with operations in flight.
        for (int i = 0; i < 5; i++) begin
            in1 = 32'h1111_1111 * i; in2 = 32'd9; cin = 1'b1; op = 1'b0; in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sum", sum, 0);
        exp_q.delete();
        @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 8; i++) begin
            check("post_rst_no_stale", out_valid, 0);
            cycle();
        end
        run_one("post_rst_add", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0,
                32'h2345_6789, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
